// File: rtl/key_event_arbiter.sv
// key_event_arbiter: round-robin serialiser of one-cycle key pulses into a small
// event FIFO with valid/ready output. Optional drop counter: `KEY_EVT_DROP_CNT_EN.
module key_event_arbiter #(
   parameter int N      = 4,
   parameter int CODE_W = 2,
   parameter int DEPTH  = 4,
   parameter int PTR_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N-1:0]      key_pulse,
   output logic              evt_valid,
   output logic [CODE_W-1:0] evt_code,
   input  logic              evt_ready,
   output logic [N-1:0]      pending,
   output logic [PTR_W:0]    fifo_cnt,
   output logic              drop_pulse,
   output logic [7:0]        drop_cnt
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_GRANT = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [N-1:0]      pending_q, pending_d;
   logic [CODE_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [CODE_W-1:0] mem_q [DEPTH];
   logic [CODE_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    cnt_q, cnt_d;
   logic              drop_pulse_q, drop_pulse_d;

   logic              push_ok, push, pop;
   logic [N-1:0]      grant_vec;
   logic [CODE_W-1:0] grant_code;
   logic [CODE_W-1:0] idx;
   int                sum;

   assign evt_valid = (cnt_q != '0);
   assign pop       = evt_valid & evt_ready;
   // A pop in the same cycle frees the slot the grant is about to fill.
   assign push_ok   = (cnt_q < (PTR_W+1)'(DEPTH)) | pop;

   always_comb begin : arbiter
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      grant_vec  = '0;
      grant_code = '0;
      push       = 1'b0;
      sum        = 0;
      idx        = '0;
      if (state_q == S_GRANT && push_ok) begin
         for (int off = 1; off <= N; off++) begin
            sum = int'(rr_ptr_q) + off;
            if (sum >= N) sum = sum - N;
            idx = CODE_W'(sum);
            if (!push && pending_q[idx]) begin
               push           = 1'b1;
               grant_vec[idx] = 1'b1;
               grant_code     = idx;
            end
         end
      end
   end

   always_comb begin : next_state
      // A fresh pulse on the key being granted re-arms its request instead of dropping.
      pending_d    = (pending_q & ~grant_vec) | key_pulse;
      drop_pulse_d = |(key_pulse & pending_q & ~grant_vec);
      rr_ptr_d     = push ? grant_code : rr_ptr_q;

      state_d = state_q;
      case (state_q)
         S_IDLE:  if (pending_d != '0) state_d = S_GRANT;
         default: if (pending_d == '0) state_d = S_IDLE;
      endcase

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = grant_code;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         pending_q    <= '0;
         rr_ptr_q     <= CODE_W'(N-1);
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         drop_pulse_q <= 1'b0;
         // NOTE: the FIFO storage is reset too, so evt_code reads 0 straight out of reset.
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q      <= state_d;
         pending_q    <= pending_d;
         rr_ptr_q     <= rr_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         drop_pulse_q <= drop_pulse_d;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end

`ifdef KEY_EVT_DROP_CNT_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop_pulse_q && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) drop_cnt_q <= 8'h00;
      else     drop_cnt_q <= drop_cnt_d;
   end

   assign drop_cnt = drop_cnt_q;
`else
   assign drop_cnt = 8'h00;
`endif

   assign evt_code   = mem_q[rd_ptr_q];
   assign pending    = pending_q;
   assign fifo_cnt   = cnt_q;
   assign drop_pulse = drop_pulse_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed bench for key_event_arbiter: reset, single press, simultaneous presses,
// backpressure, duplicate drop and set-wins, against hand-computed expectations.
module tb_key_event_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] key_pulse;
   logic       evt_valid;
   logic [1:0] evt_code;
   logic       evt_ready;
   logic [3:0] pending;
   logic [2:0] fifo_cnt;
   logic       drop_pulse;
   logic [7:0] drop_cnt;

   int checks = 0;
   int errors = 0;

   key_event_arbiter #(.N(4), .CODE_W(2), .DEPTH(4), .PTR_W(2)) dut (
      .clk(clk), .rst(rst), .key_pulse(key_pulse),
      .evt_valid(evt_valid), .evt_code(evt_code), .evt_ready(evt_ready),
      .pending(pending), .fifo_cnt(fifo_cnt),
      .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      key_pulse = 4'b0000;
      evt_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic pulse(input logic [3:0] keys);
      key_pulse = keys;
      tick();
      key_pulse = 4'b0000;
   endtask

   // Check head, pop exactly one event, drop ready again.
   task automatic pop_check(input string tag, input logic [1:0] exp);
      check({tag, "_valid"}, 32'(evt_valid), 32'd1);
      check({tag, "_code"}, 32'(evt_code), 32'(exp));
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
   endtask

   logic [1:0] bp_seq [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
   logic [7:0] exp_drop_cnt;

   initial begin
`ifdef KEY_EVT_DROP_CNT_EN
      exp_drop_cnt = 8'd1;
`else
      exp_drop_cnt = 8'd0;
`endif

      // 1 Reset, including an asynchronous reset mid-traffic.
      do_reset();
      check("rst_valid", 32'(evt_valid), 0);
      check("rst_cnt", 32'(fifo_cnt), 0);
      check("rst_pending", 32'(pending), 0);
      check("rst_drop_cnt", 32'(drop_cnt), 0);
      pulse(4'b1111);
      check("t1_pending", 32'(pending), 32'hF);
      tick();
      check("t1_pre_code", 32'(evt_code), 0);
      check("t1_pre_cnt", 32'(fifo_cnt), 1);
      rst = 1'b1;
      #2;
      check("async_valid", 32'(evt_valid), 0);
      check("async_code", 32'(evt_code), 0);
      check("async_cnt", 32'(fifo_cnt), 0);
      check("async_pending", 32'(pending), 0);
      check("async_drop", 32'(drop_pulse), 0);
      check("async_drop_cnt", 32'(drop_cnt), 0);
      do_reset();
      pulse(4'b1111);
      tick();
      pop_check("t1_g0", 2'd0);
      pop_check("t1_g1", 2'd1);
      pop_check("t1_g2", 2'd2);
      pop_check("t1_g3", 2'd3);
      check("t1_empty", 32'(fifo_cnt), 0);

      // 2 Single press, 2-cycle latency, pop on empty ignored.
      do_reset();
      evt_ready = 1'b1;
      pulse(4'b0100);
      check("t2_pending", 32'(pending), 32'h4);
      check("t2_early_valid", 32'(evt_valid), 0);
      tick();
      check("t2_valid", 32'(evt_valid), 1);
      check("t2_code", 32'(evt_code), 2);
      check("t2_cnt1", 32'(fifo_cnt), 1);
      tick();
      check("t2_gone", 32'(evt_valid), 0);
      check("t2_cnt0", 32'(fifo_cnt), 0);
      tick();
      check("t2_empty_pop", 32'(fifo_cnt), 0);

      // 3 Simultaneous presses with streaming consumer.
      do_reset();
      evt_ready = 1'b1;
      pulse(4'b1011);
      tick(); check("t3_a0", 32'(evt_code), 0);
      tick(); check("t3_a1", 32'(evt_code), 1);
      tick(); check("t3_a3", 32'(evt_code), 3);
      check("t3_a3_valid", 32'(evt_valid), 1);
      tick(); check("t3_a_done", 32'(evt_valid), 0);
      pulse(4'b0011);
      tick(); check("t3_b0", 32'(evt_code), 0);
      tick(); check("t3_b1", 32'(evt_code), 1);
      tick(); check("t3_b_done", 32'(evt_valid), 0);
      pulse(4'b1111);
      tick(); check("t3_c2", 32'(evt_code), 2);
      tick(); check("t3_c3", 32'(evt_code), 3);
      tick(); check("t3_c0", 32'(evt_code), 0);
      tick(); check("t3_c1", 32'(evt_code), 1);
      tick(); check("t3_c_done", 32'(evt_valid), 0);

      // 4 Backpressure: FIFO fills, remaining requests wait in pending.
      do_reset();
      pulse(4'b1111);
      repeat (5) tick();
      check("t4_full", 32'(fifo_cnt), 4);
      check("t4_pend0", 32'(pending), 0);
      pulse(4'b1111);
      check("t4_pend1", 32'(pending), 32'hF);
      check("t4_nodrop", 32'(drop_pulse), 0);
      tick();
      check("t4_hold_pend", 32'(pending), 32'hF);
      check("t4_hold_cnt", 32'(fifo_cnt), 4);
      evt_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("t4_seq%0d", i), 32'(evt_code), 32'(bp_seq[i]));
         check($sformatf("t4_drop%0d", i), 32'(drop_pulse), 0);
         tick();
      end
      check("t4_drained", 32'(fifo_cnt), 0);
      check("t4_pend_end", 32'(pending), 0);

      // 5 Duplicate press while pending and FIFO full.
      do_reset();
      pulse(4'b1111);
      repeat (5) tick();
      pulse(4'b0010);
      check("t5_pend", 32'(pending), 32'h2);
      check("t5_nodrop", 32'(drop_pulse), 0);
      pulse(4'b0010);
      check("t5_drop", 32'(drop_pulse), 1);
      check("t5_cnt_before", 32'(drop_cnt), 0);
      tick();
      check("t5_drop_end", 32'(drop_pulse), 0);
      check("t5_drop_cnt", 32'(drop_cnt), 32'(exp_drop_cnt));
      check("t5_pend_kept", 32'(pending), 32'h2);

      // 6 Set-wins: new pulse on key 2 in its grant cycle.
      do_reset();
      evt_ready = 1'b1;
      pulse(4'b0100);
      pulse(4'b0100);
      check("t6_code1", 32'(evt_code), 2);
      check("t6_pend_kept", 32'(pending), 32'h4);
      check("t6_nodrop", 32'(drop_pulse), 0);
      tick();
      check("t6_valid2", 32'(evt_valid), 1);
      check("t6_code2", 32'(evt_code), 2);
      check("t6_pend_clr", 32'(pending), 0);
      tick();
      check("t6_done", 32'(evt_valid), 0);
      check("t6_nodrop_end", 32'(drop_pulse), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
